// File: rtl/cdb_broadcast_arb.sv
// Two-lane common data bus producer: round-robin arbitration over the
// functional-unit writeback ports with one-entry holding registers per source.
module cdb_broadcast_arb #(
    parameter int N_SRC  = 5,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int XLEN   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        fu_valid,
    input  logic [N_SRC*PREG_W-1:0] fu_tag,
    input  logic [N_SRC*XLEN-1:0]   fu_value,
    input  logic [N_SRC*ROB_W-1:0]  fu_rob_idx,
    output logic [N_SRC-1:0]        fu_stall,
    output logic [1:0]              cdb_valid,
    output logic [2*PREG_W-1:0]     cdb_tag,
    output logic [2*XLEN-1:0]       cdb_value,
    output logic [2*ROB_W-1:0]      cdb_rob_idx,
    output logic                    arb_busy
);

    localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  hold_v;
    logic [PREG_W-1:0] hold_tag   [N_SRC];
    logic [XLEN-1:0]   hold_value [N_SRC];
    logic [ROB_W-1:0]  hold_rob   [N_SRC];
    logic [PTR_W-1:0]  rr_ptr;

    logic [N_SRC-1:0]  cand_v;
    logic [PREG_W-1:0] cand_tag   [N_SRC];
    logic [XLEN-1:0]   cand_value [N_SRC];
    logic [ROB_W-1:0]  cand_rob   [N_SRC];

    logic [N_SRC-1:0]  grant;
    logic              g0_v, g1_v;
    logic [PTR_W-1:0]  g0_idx, g1_idx;
    logic [PTR_W-1:0]  last_idx;
    logic [PTR_W-1:0]  rr_next;

    // Position k steps after base in the circular source order.
    function automatic logic [PTR_W-1:0] wrap_idx(
        input logic [PTR_W-1:0] base,
        input int               k
    );
        int s;
        s = int'(base) + k;
        if (s >= N_SRC) s = s - N_SRC;
        return PTR_W'(s);
    endfunction

    // A held entry masks the live input of its source.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cand_v[i]     = hold_v[i] | fu_valid[i];
            cand_tag[i]   = hold_v[i] ? hold_tag[i]
                                      : fu_tag[i*PREG_W +: PREG_W];
            cand_value[i] = hold_v[i] ? hold_value[i]
                                      : fu_value[i*XLEN +: XLEN];
            cand_rob[i]   = hold_v[i] ? hold_rob[i]
                                      : fu_rob_idx[i*ROB_W +: ROB_W];
        end
    end

    // Round-robin scan from rr_ptr picking the first two candidates.
    always_comb begin
        logic [PTR_W-1:0] j;
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        grant  = '0;
        j      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            j = wrap_idx(rr_ptr, k);
            if (cand_v[j]) begin
                if (!g0_v) begin
                    g0_v     = 1'b1;
                    g0_idx   = j;
                    grant[j] = 1'b1;
                end else if (!g1_v) begin
                    g1_v     = 1'b1;
                    g1_idx   = j;
                    grant[j] = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the last source granted this cycle.
    always_comb begin
        last_idx = g1_v ? g1_idx : g0_idx;
        rr_next  = wrap_idx(last_idx, 1);
    end

    // Holding registers, pointer and registered CDB lanes.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_v      <= '0;
            rr_ptr      <= '0;
            cdb_valid   <= 2'b00;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_idx <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                hold_tag[i]   <= '0;
                hold_value[i] <= '0;
                hold_rob[i]   <= '0;
            end
        end else if (flush) begin
            hold_v    <= '0;
            cdb_valid <= 2'b00;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end else if (!hold_v[i] && fu_valid[i]) begin
                    hold_v[i]     <= 1'b1;
                    hold_tag[i]   <= fu_tag[i*PREG_W +: PREG_W];
                    hold_value[i] <= fu_value[i*XLEN +: XLEN];
                    hold_rob[i]   <= fu_rob_idx[i*ROB_W +: ROB_W];
                end
            end
            cdb_valid <= {g1_v, g0_v};
            if (g0_v) begin
                cdb_tag[0 +: PREG_W]    <= cand_tag[g0_idx];
                cdb_value[0 +: XLEN]    <= cand_value[g0_idx];
                cdb_rob_idx[0 +: ROB_W] <= cand_rob[g0_idx];
            end
            if (g1_v) begin
                cdb_tag[PREG_W +: PREG_W] <= cand_tag[g1_idx];
                cdb_value[XLEN +: XLEN]   <= cand_value[g1_idx];
                cdb_rob_idx[ROB_W +: ROB_W] <= cand_rob[g1_idx];
            end
            if (g0_v) rr_ptr <= rr_next;
        end
    end

    assign fu_stall = hold_v;
    assign arb_busy = |hold_v;

endmodule

// File: tb/tb_cdb_broadcast_arb.sv
// Bench for cdb_broadcast_arb: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_cdb_broadcast_arb;

    localparam int N  = 5;
    localparam int PW = 6;
    localparam int XW = 32;
    localparam int RW = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N*PW-1:0] fu_tag;
    logic [N*XW-1:0] fu_value;
    logic [N*RW-1:0] fu_rob_idx;
    logic [N-1:0]    fu_stall;
    logic [1:0]      cdb_valid;
    logic [2*PW-1:0] cdb_tag;
    logic [2*XW-1:0] cdb_value;
    logic [2*RW-1:0] cdb_rob_idx;
    logic            arb_busy;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit          mh_v   [N];
    logic [5:0]  mh_tag [N];
    logic [31:0] mh_val [N];
    logic [4:0]  mh_rob [N];
    int          m_rr;
    bit          mc_v   [2];
    logic [5:0]  mc_tag [2];
    logic [31:0] mc_val [2];
    logic [4:0]  mc_rob [2];

    cdb_broadcast_arb dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_value   (fu_value),
        .fu_rob_idx (fu_rob_idx),
        .fu_stall   (fu_stall),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .cdb_rob_idx(cdb_rob_idx),
        .arb_busy   (arb_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [5:0] t,
                           input logic [31:0] v, input logic [4:0] r);
        fu_tag[i*PW +: PW]     = t;
        fu_value[i*XW +: XW]   = v;
        fu_rob_idx[i*RW +: RW] = r;
    endtask

    // Apply the arbitration rules to the model for one rising edge.
    task automatic model_edge();
        bit          cv [N];
        logic [5:0]  ct [N];
        logic [31:0] cval [N];
        logic [4:0]  cr [N];
        bit          won [N];
        int          g[$];
        int          s;
        if (reset) begin
            for (int i = 0; i < N; i++) mh_v[i] = 0;
            m_rr = 0;
            for (int l = 0; l < 2; l++) begin
                mc_v[l] = 0; mc_tag[l] = '0;
                mc_val[l] = '0; mc_rob[l] = '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N; i++) mh_v[i] = 0;
            mc_v[0] = 0;
            mc_v[1] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                won[i] = 0;
                cv[i] = mh_v[i] || fu_valid[i];
                ct[i] = mh_v[i] ? mh_tag[i] : fu_tag[i*PW +: PW];
                cval[i] = mh_v[i] ? mh_val[i] : fu_value[i*XW +: XW];
                cr[i] = mh_v[i] ? mh_rob[i] : fu_rob_idx[i*RW +: RW];
            end
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (cv[s] && g.size() < 2) begin
                    g.push_back(s);
                    won[s] = 1;
                end
            end
            for (int l = 0; l < 2; l++) begin
                if (l < g.size()) begin
                    mc_v[l] = 1;
                    mc_tag[l] = ct[g[l]];
                    mc_val[l] = cval[g[l]];
                    mc_rob[l] = cr[g[l]];
                end else begin
                    mc_v[l] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (won[i]) mh_v[i] = 0;
                else if (cv[i] && !mh_v[i]) begin
                    mh_v[i] = 1; mh_tag[i] = ct[i];
                    mh_val[i] = cval[i]; mh_rob[i] = cr[i];
                end
            end
            if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % N;
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        logic [4:0] es;
        @(posedge clock);
        model_edge();
        #1;
        es = '0;
        for (int i = 0; i < N; i++) es[i] = mh_v[i];
        chk("cdb_valid", 64'(cdb_valid), 64'({mc_v[1], mc_v[0]}));
        chk("cdb_tag", 64'(cdb_tag), 64'({mc_tag[1], mc_tag[0]}));
        chk("cdb_value", cdb_value, {mc_val[1], mc_val[0]});
        chk("cdb_rob", 64'(cdb_rob_idx), 64'({mc_rob[1], mc_rob[0]}));
        chk("fu_stall", 64'(fu_stall), 64'(es));
        chk("arb_busy", 64'(arb_busy), 64'(|es));
    endtask

    initial begin
        logic [5:0] t0;
        logic [5:0] t1;
        reset = 1; flush = 0; fu_valid = '0;
        fu_tag = '0; fu_value = '0; fu_rob_idx = '0;

        // reset then idle
        step(); step();
        reset = 0;
        for (int c = 0; c < 3; c++) step();
        chk("idle_valid", 64'(cdb_valid), 64'd0);

        // single request from mult
        set_src(2, 6'd17, 32'hDEADBEEF, 5'd3);
        fu_valid = 5'b00100;
        step();
        fu_valid = '0;
        chk("single_v", 64'(cdb_valid), 64'd1);
        chk("single_tag", 64'(cdb_tag[5:0]), 64'd17);
        chk("single_val", 64'(cdb_value[31:0]), 64'hDEADBEEF);
        chk("single_rob", 64'(cdb_rob_idx[4:0]), 64'd3);
        chk("single_stall", 64'(fu_stall), 64'd0);
        step();

        // all sources from rr_ptr=0
        reset = 1; step(); reset = 0;
        for (int i = 0; i < N; i++)
            set_src(i, 6'(i + 1), 32'h100 + i, 5'(i));
        fu_valid = 5'b11111;
        step();
        chk("all1_v", 64'(cdb_valid), 64'd3);
        chk("all1_tags", 64'(cdb_tag), 64'({6'd2, 6'd1}));
        chk("all1_stall", 64'(fu_stall), 64'b11100);
        set_src(0, 6'd6, 32'h200, 5'd10);
        set_src(1, 6'd7, 32'h201, 5'd11);
        fu_valid = 5'b00011;
        step();
        chk("all2_tags", 64'(cdb_tag), 64'({6'd4, 6'd3}));
        step();
        chk("all3_tags", 64'(cdb_tag), 64'({6'd6, 6'd5}));
        step();
        t0 = cdb_tag[5:0];
        chk("all4_lane0", 64'(t0), 64'd7);
        fu_valid = '0;
        step(); step(); step();

        // wrap-around: drive rr_ptr to 4 first
        reset = 1; step(); reset = 0;
        fu_valid = 5'b01111;
        step();
        fu_valid = '0;
        step(); step();
        set_src(4, 6'd40, 32'h44, 5'd4);
        set_src(0, 6'd0, 32'h0, 5'd0);
        fu_valid = 5'b10001;
        step();
        chk("wrap_tags", 64'(cdb_tag), 64'({6'd0, 6'd40}));
        set_src(1, 6'd41, 32'h45, 5'd5);
        set_src(0, 6'd42, 32'h46, 5'd6);
        fu_valid = 5'b00011;
        step();
        t1 = cdb_tag[5:0];
        chk("wrap_rr1", 64'(t1), 64'd41);
        fu_valid = '0;
        step();

        // flush with held entries
        reset = 1; step(); reset = 0;
        fu_valid = 5'b11111;
        step();
        chk("fl_hold", 64'(fu_stall), 64'b11100);
        flush = 1;
        fu_valid = 5'b00011;
        step();
        flush = 0;
        fu_valid = '0;
        chk("fl_valid", 64'(cdb_valid), 64'd0);
        chk("fl_stall", 64'(fu_stall), 64'd0);
        chk("fl_busy", 64'(arb_busy), 64'd0);
        step();
        chk("fl_drop", 64'(cdb_valid), 64'd0);

        // reset mid-operation
        reset = 1; step(); reset = 0;
        fu_valid = 5'b11111;
        step();
        fu_valid = 5'b00011;
        step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_value", cdb_value, 64'd0);
        chk("rst_stall", 64'(fu_stall), 64'd0);
        set_src(0, 6'd50, 32'h50, 5'd1);
        set_src(4, 6'd54, 32'h54, 5'd2);
        fu_valid = 5'b10001;
        step();
        chk("rst_rr0", 64'(cdb_tag), 64'({6'd54, 6'd50}));

        // random traffic
        fu_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                set_src(i, 6'($urandom), $urandom, 5'($urandom));
            fu_valid = 5'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 0; flush = 0; fu_valid = '0;
        step(); step(); step();
        chk("drain_busy", 64'(arb_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
